// File: rtl/key_schedule_seq.sv
// key_schedule_seq
//   Iterative AES-128 key expansion. Loads a 128-bit cipher key and presents
//   round keys 0..NR one at a time on a valid/ready stream. Each accepted
//   round key is replaced on the next edge by its successor, which is computed
//   from the current key with a 4-byte SubWord and the Rcon table.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a new expansion; sampled only while idle
//   key_in     cipher key, byte 0 = key_in[127:120]
//   rk_valid   round_key / rk_index hold a valid round key
//   rk_ready   consumer accepts the current round key
//   round_key  current round key, same byte order as key_in
//   rk_index   round number of round_key, 0..NR
//   busy       expansion in progress
//   done       one-cycle pulse after round key NR transfers
module key_schedule_seq #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int unsigned i;
    i = 32'(b);
    return SBOX[2047 - 8*i -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One step of the FIPS-197 schedule: w0..w3 -> w4..w7.
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rc, 24'h000000};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t state;

  // rk_index doubles as the Rcon index: key i+1 uses rcon[i].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      rk_index  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            rk_index  <= '0;
            rk_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rk_valid && rk_ready) begin
            if (rk_index == LAST) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              round_key <= expand(round_key, rcon(rk_index));
              rk_index  <= rk_index + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;

  logic         clk;
  logic         rst_n;
  logic         start, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, round_key;
  logic [3:0]   rk_index;

  logic         start_b, rk_ready_b, rk_valid_b, busy_b, done_b;
  logic [127:0] key_in_b, round_key_b;
  logic [3:0]   rk_index_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  key_schedule_seq #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .rk_index(rk_index), .busy(busy), .done(done)
  );

  key_schedule_seq #(.NR(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_in_b),
    .rk_valid(rk_valid_b), .rk_ready(rk_ready_b), .round_key(round_key_b),
    .rk_index(rk_index_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] got     [0:10];

  typedef struct {
    logic [127:0] key;
    int unsigned  idx;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one full NR=10 expansion on dut, recording each transferred key.
  task automatic run_a(input logic [127:0] key, input bit rand_ready, input bit inject);
    int unsigned  expect_idx = 0;
    int unsigned  cyc = 0;
    int unsigned  first_cyc = 0;
    int unsigned  last_cyc = 0;
    bit           fin = 1'b0;
    bit           stalled = 1'b0;
    logic [127:0] hold_key = '0;
    logic [3:0]   hold_idx = '0;
    for (int i = 0; i < 11; i++) got[i] = '0;
    @(negedge clk);
    start = 1'b1; key_in = key; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_valid", 128'(rk_valid), 128'd1);
    chk("start_busy", 128'(busy), 128'd1);
    while (!fin && cyc < 200) begin
      if (rk_valid) begin
        if (stalled) begin
          chk("stall_key_hold", round_key, hold_key);
          chk("stall_idx_hold", 128'(rk_index), 128'(hold_idx));
        end
        if (inject && cyc == 3) begin
          start = 1'b1; key_in = ~key;
        end else begin
          start = 1'b0;
        end
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_ready) begin
          chk("index_order", 128'(rk_index), 128'(expect_idx));
          got[expect_idx] = round_key;
          if (expect_idx == 0) first_cyc = cyc;
          last_cyc = cyc;
          expect_idx++;
          stalled = 1'b0;
          if (expect_idx == 11) fin = 1'b1;
        end else begin
          stalled  = 1'b1;
          hold_key = round_key;
          hold_idx = rk_index;
        end
      end else begin
        chk("valid_held_mid_run", 128'(rk_valid), 128'd1);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) chk("expansion_timeout", 128'(expect_idx), 128'd11);
    if (!rand_ready) chk("burst_span", 128'(last_cyc - first_cyc + 1), 128'd11);
    chk("done_pulse", 128'(done), 128'd1);
    chk("valid_after_last", 128'(rk_valid), 128'd0);
    chk("busy_after_last", 128'(busy), 128'd0);
    chk("idx_hold_after_last", 128'(rk_index), 128'd10);
    chk("key_hold_after_last", round_key, got[10]);
    rk_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    for (int i = 0; i < 11; i++) vecs[i] = '{FIPS_KEY, 32'(i), fips_rk[i]};
    vecs[11] = '{ZERO_KEY, 1,  128'h62636363626363636263636362636363};
    vecs[12] = '{ZERO_KEY, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[13] = '{ZERO_KEY, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n = 1'b0;
    start = 1'b0; key_in = '0; rk_ready = 1'b0;
    start_b = 1'b0; key_in_b = '0; rk_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_key", round_key, 128'd0);
    chk("reset_idx", 128'(rk_index), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one expansion per distinct key, then compare the listed indices.
    for (int i = 0; i < 14; i++) begin
      if (i == 0 || vecs[i].key != vecs[i-1].key) run_a(vecs[i].key, 1'b0, 1'b0);
      chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
    end

    // Random backpressure on the FIPS key.
    run_a(FIPS_KEY, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) chk($sformatf("randready_idx%0d", i), got[i], fips_rk[i]);

    // start with a different key while busy must be ignored.
    run_a(FIPS_KEY, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) chk($sformatf("inject_idx%0d", i), got[i], fips_rk[i]);

    // Asynchronous reset after idx4 has transferred.
    @(negedge clk);
    start = 1'b1; key_in = FIPS_KEY;
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_idx", 128'(rk_index), 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(rk_valid), 128'd0);
    chk("async_busy", 128'(busy), 128'd0);
    chk("async_key", round_key, 128'd0);
    chk("async_idx", 128'(rk_index), 128'd0);
    chk("async_done", 128'(done), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_partial_done", 128'(done), 128'd0);
      chk("idle_after_reset", 128'(rk_valid), 128'd0);
    end
    start = 1'b1; key_in = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    start = 1'b0;
    chk("fresh_valid", 128'(rk_valid), 128'd1);
    chk("fresh_idx0", 128'(rk_index), 128'd0);
    chk("fresh_key0", round_key, 128'h000102030405060708090a0b0c0d0e0f);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // NR=4 instance with start held high through done.
    start_b = 1'b1; key_in_b = FIPS_KEY; rk_ready_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("nr4_valid%0d", i), 128'(rk_valid_b), 128'd1);
      chk($sformatf("nr4_idx%0d", i), 128'(rk_index_b), 128'(i));
      chk($sformatf("nr4_key%0d", i), round_key_b, fips_rk[i]);
    end
    @(negedge clk);
    chk("nr4_done", 128'(done_b), 128'd1);
    chk("nr4_valid_low", 128'(rk_valid_b), 128'd0);
    key_in_b = ZERO_KEY;
    @(negedge clk);
    chk("nr4_restart_valid", 128'(rk_valid_b), 128'd1);
    chk("nr4_restart_idx", 128'(rk_index_b), 128'd0);
    chk("nr4_restart_key", round_key_b, ZERO_KEY);
    chk("nr4_restart_done_low", 128'(done_b), 128'd0);
    chk("nr4_restart_busy", 128'(busy_b), 128'd1);
    start_b = 1'b0;
    begin
      int unsigned n = 0;
      while (!done_b && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("nr4_second_done", 128'(done_b), 128'd1);
      chk("nr4_second_cycles", 128'(n), 128'd5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
